game_screen_sm: RTL and testbench
=================================

# game_screen_sm

Game-flow controller and full-screen renderer for the non-gameplay screens. It produces the `game_on` select and the `RGB_game_sm` pixel stream that the final VGA RGB mux consumes. The mux passes the object-mux image when `game_on=1` and this block's image otherwise. The block sequences start, ready, play, win and lose screens from key and game events. State changes are applied only on frame boundaries, so a switch never tears a frame.

## Interface
Parameters:
- `READY_FRAMES`, 120: frames shown on the READY screen before play starts.
- `WIN_FRAMES`, 180: frames shown on the WIN screen.
- `LOSE_FRAMES`, 180: frames shown on the LOSE screen.
- `BLINK_FRAMES`, 30: frames per blink half-period of the banner.
- `BANNER_X0`, `BANNER_X1`, `BANNER_Y0`, `BANNER_Y1`; defaults 160, 480, 200, 280: banner rectangle, half-open `[X0,X1)×[Y0,Y1)`.
- All frame parameters must be in the range 1..511.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame from the VGA controller.
- `pixelX` in 11: current pixel column.
- `pixelY` in 11: current pixel row.
- `key_start` in 1: debounced start key, level.
- `player_dead` in 1: pulse or level from game logic.
- `level_cleared` in 1: pulse or level from game logic.
- `game_on` out 1: 1 only in PLAY; drives the RGB mux select.
- `RGB_game_sm` out 8: RRRGGGBB screen pixel.
- `new_game` out 1: one-cycle pulse on entry to PLAY; resets game objects.
- `screen_state` out 3: current state encoding, for sound/debug.

## Operation
- States and encodings: START=0, READY=1, PLAY=2, WIN=3, LOSE=4.
- Event capture, every cycle:
  - Rising edge of `key_start` (registered previous value) sets sticky `key_evt`.
  - `player_dead=1` sets `dead_evt`; `level_cleared=1` sets `clr_evt`.
  - Flags are cleared in the cycle the FSM changes state.
- FSM evaluation happens only in cycles with `startOfFrame=1`.
- Frame counter `frm_cnt` (9 bits) is loaded on state entry and decrements by 1 per `startOfFrame` while non-zero.
- Transitions:
  - START: on `key_evt` → READY; load `frm_cnt=READY_FRAMES`.
  - READY: when `frm_cnt==1` at `startOfFrame` → PLAY; pulse `new_game`.
  - PLAY: `dead_evt` → LOSE (load `LOSE_FRAMES`); else `clr_evt` → WIN (load `WIN_FRAMES`). If both are set, LOSE has priority.
  - WIN/LOSE: `frm_cnt==1` → START. A `key_evt` skips early → START.
- Blink:
  - `blink_cnt` counts `startOfFrame` pulses 0..BLINK_FRAMES-1; `blink_ph` toggles on wrap.
  - Both are reset to 0 on every state change.
- Pixel colour:
  - Inside the banner, START/WIN/LOSE show 8'hFF when `blink_ph=1` and the background colour otherwise. READY shows a solid 8'hFC banner.
  - Outside the banner, the background is START 8'h03, READY 8'h00, WIN 8'h1C, LOSE 8'hE0.
  - PLAY outputs 8'h00.
- Inputs that are ignored:
  - `key_start` is ignored in READY and PLAY; its flag is held and cleared at the next state change.
  - `player_dead` and `level_cleared` are ignored outside PLAY.

## Timing
- Reset values: state START, `game_on=0`, `RGB_game_sm=8'h00`, `new_game=0`, `screen_state=0`, all counters, flags and `blink_ph` = 0.
- Reset mid-operation returns to START immediately, asynchronously.
- `RGB_game_sm` is registered: 1-cycle latency from `pixelX`/`pixelY`, matching the object-mux pipeline.
- `game_on` and `screen_state` are registered and change on the clock edge after the `startOfFrame` cycle.
- `new_game` is high for exactly that same cycle.
- An event arriving in the same cycle as `startOfFrame` is not seen until the next frame, one frame of latency.
- READY lasts exactly `READY_FRAMES` `startOfFrame` pulses; the same holds for WIN and LOSE.
- Counter arithmetic is unsigned and never wraps below 0.

## Structure
- Shared package `game_screen_pkg`:
  - `typedef enum logic [2:0]` of the five state encodings.
  - Colour constants `COL_START_BG`, `COL_READY_BG`, `COL_WIN_BG`, `COL_LOSE_BG`, `COL_BANNER`, `COL_READY_BANNER`.
  - These are also imported by the sound block.
- One sub-module, `frame_timer`: a loadable 9-bit down-counter plus the blink divider, both clocked by `startOfFrame`.
- The FSM, event flags and pixel register stay in the top.

## Test plan
- Reset, then 3 frames idle → `game_on=0`, `screen_state=0`, pixel (0,0) = 8'h03, pixel (300,240) toggles 8'hFF/8'h03 every 30 frames.
- `key_start` 0→1 mid-frame → READY at next `startOfFrame`; after 120 more pulses `game_on=1` and `new_game` is high for one cycle.
- In PLAY, assert `player_dead` and `level_cleared` together → LOSE (`screen_state=4`), pixel (0,0) = 8'hE0; after 180 frames → START.
- In PLAY, `level_cleared` pulse → WIN; `key_start` edge at frame 10 → START at the following `startOfFrame`.
- Hold `key_start` high through READY into PLAY → no extra transition; `player_dead` in START → ignored.
- Assert `resetN=0` in WIN mid-frame → outputs go to reset values asynchronously; release → START screen.

Source files
------------

// File: rtl/game_screen_pkg.sv
// Shared screen-state encodings and palette for the game-flow controller.
// The sound block imports the same encodings and colours.
package game_screen_pkg;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } screen_t;

  localparam int FRM_W = 9;

  // RRRGGGBB colours
  localparam logic [7:0] COL_START_BG     = 8'h03;
  localparam logic [7:0] COL_READY_BG     = 8'h00;
  localparam logic [7:0] COL_WIN_BG       = 8'h1C;
  localparam logic [7:0] COL_LOSE_BG      = 8'hE0;
  localparam logic [7:0] COL_BANNER       = 8'hFF;
  localparam logic [7:0] COL_READY_BANNER = 8'hFC;
  localparam logic [7:0] COL_PLAY         = 8'h00;

endpackage

// File: rtl/game_screen_sm_frame_timer.sv
// Frame-rate timing for the screen FSM: loadable down-counter and banner blink divider.
// Both advance only on startOfFrame; load also restarts the blink phase.
module frame_timer
  import game_screen_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             load,
  input  logic [FRM_W-1:0] load_val,
  output logic [FRM_W-1:0] frm_cnt,
  output logic             blink_ph
);

  localparam logic [FRM_W-1:0] BLINK_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (load) begin
      frm_cnt   <= load_val;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (sof) begin
      if (frm_cnt != '0) frm_cnt <= frm_cnt - 1'b1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_screen_sm.sv
// Game-flow FSM and full-screen renderer for START/READY/WIN/LOSE screens.
// State only moves on startOfFrame so a screen switch never tears a frame.
module game_screen_sm
  import game_screen_pkg::*;
#(
  parameter int READY_FRAMES = 120,
  parameter int WIN_FRAMES   = 180,
  parameter int LOSE_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30,
  parameter int BANNER_X0    = 160,
  parameter int BANNER_X1    = 480,
  parameter int BANNER_Y0    = 200,
  parameter int BANNER_Y1    = 280
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        key_start,
  input  logic        player_dead,
  input  logic        level_cleared,
  output logic        game_on,
  output logic [7:0]  RGB_game_sm,
  output logic        new_game,
  output logic [2:0]  screen_state
);

  screen_t          state, state_nxt;
  logic             change, new_game_d;
  logic             key_prev, key_evt, dead_evt, clr_evt;
  logic [FRM_W-1:0] frm_cnt, load_val;
  logic             blink_ph, in_banner;
  logic [7:0]       rgb_d;

  assign change = (state_nxt != state);

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_START;
    else         state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    if (startOfFrame) begin
      case (state)
        S_START: if (key_evt) state_nxt = S_READY;
        S_READY: if (frm_cnt == 9'd1) state_nxt = S_PLAY;
        S_PLAY: begin
          if (dead_evt)     state_nxt = S_LOSE;
          else if (clr_evt) state_nxt = S_WIN;
        end
        S_WIN, S_LOSE: if (key_evt || frm_cnt == 9'd1) state_nxt = S_START;
        default: state_nxt = S_START;
      endcase
    end
  end

  // outputs
  always_comb begin
    game_on      = (state == S_PLAY);
    screen_state = state;
    new_game_d   = change && (state_nxt == S_PLAY);
    case (state_nxt)
      S_READY: load_val = FRM_W'(READY_FRAMES);
      S_WIN:   load_val = FRM_W'(WIN_FRAMES);
      S_LOSE:  load_val = FRM_W'(LOSE_FRAMES);
      default: load_val = '0;
    endcase
    case (state)
      S_START: rgb_d = (in_banner && blink_ph) ? COL_BANNER : COL_START_BG;
      S_READY: rgb_d = in_banner ? COL_READY_BANNER : COL_READY_BG;
      S_WIN:   rgb_d = (in_banner && blink_ph) ? COL_BANNER : COL_WIN_BG;
      S_LOSE:  rgb_d = (in_banner && blink_ph) ? COL_BANNER : COL_LOSE_BG;
      default: rgb_d = COL_PLAY;
    endcase
  end

  assign in_banner = (pixelX >= 11'(BANNER_X0)) && (pixelX < 11'(BANNER_X1)) &&
                     (pixelY >= 11'(BANNER_Y0)) && (pixelY < 11'(BANNER_Y1));

  // Sticky events; a new event in the change cycle survives into the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_prev <= 1'b0;
      key_evt  <= 1'b0;
      dead_evt <= 1'b0;
      clr_evt  <= 1'b0;
    end else begin
      key_prev <= key_start;
      key_evt  <= (key_evt  & ~change) | (key_start & ~key_prev);
      dead_evt <= (dead_evt & ~change) | (player_dead   & (state == S_PLAY));
      clr_evt  <= (clr_evt  & ~change) | (level_cleared & (state == S_PLAY));
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGB_game_sm <= 8'h00;
      new_game    <= 1'b0;
    end else begin
      RGB_game_sm <= rgb_d;
      new_game    <= new_game_d;
    end
  end

  frame_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_timer (
    .clk      (clk),
    .rst_n    (resetN),
    .sof      (startOfFrame),
    .load     (change),
    .load_val (load_val),
    .frm_cnt  (frm_cnt),
    .blink_ph (blink_ph)
  );

endmodule

// File: tb/tb_game_screen_sm.sv
// Self-checking bench for game_screen_sm: frame-level reference model counting
// start-of-frame pulses since state entry, driven with randomized pixels and events.
module tb_game_screen_sm;

  localparam int RF = 120, WF = 180, LF = 180, BF = 30, FL = 8;

  logic        clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        key_start = 1'b0, player_dead = 1'b0, level_cleared = 1'b0;
  logic        game_on, new_game;
  logic [7:0]  RGB_game_sm;
  logic [2:0]  screen_state;

  game_screen_sm dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .key_start(key_start),
    .player_dead(player_dead), .level_cleared(level_cleared),
    .game_on(game_on), .RGB_game_sm(RGB_game_sm), .new_game(new_game),
    .screen_state(screen_state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // model: state 0..4, sofs since entry, pending events
  int         m_state, m_k;
  bit         m_key, m_dead, m_clr, m_prev, m_ng;
  logic [7:0] m_rgb;
  bit         key_lvl;

  wire [12:0] dut_vec = {game_on, screen_state, new_game, RGB_game_sm};

  function automatic logic [12:0] exp_vec();
    return {m_state == 2, 3'(m_state), m_ng, m_rgb};
  endfunction

  function automatic logic [7:0] ref_col(int st, int k, int x, int y);
    bit ban = (x >= 160) && (x < 480) && (y >= 200) && (y < 280);
    bit ph  = ((k / BF) % 2) == 1;
    case (st)
      0:       return (ban && ph) ? 8'hFF : 8'h03;
      1:       return ban ? 8'hFC : 8'h00;
      3:       return (ban && ph) ? 8'hFF : 8'h1C;
      4:       return (ban && ph) ? 8'hFF : 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int rx();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(150, 490));
    return int'($urandom_range(0, 639));
  endfunction

  function automatic int ry();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(190, 290));
    return int'($urandom_range(0, 479));
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_key = 0; m_dead = 0; m_clr = 0;
    m_prev = 0; m_ng = 0; m_rgb = 8'h00;
  endtask

  // One clock: drive inputs, clock, advance model, settle 1 time unit past the edge.
  task automatic tick(input bit s, input bit k, input bit d, input bit c,
                      input int x, input int y);
    bit chg, kedge;
    int nx, kk;
    startOfFrame = s; key_start = k; player_dead = d; level_cleared = c;
    pixelX = 11'(x); pixelY = 11'(y);
    @(posedge clk);
    m_rgb = ref_col(m_state, m_k, x, y);
    nx = m_state; kk = m_k + 1;
    if (s) begin
      case (m_state)
        0: if (m_key) nx = 1;
        1: if (kk == RF) nx = 2;
        2: if (m_dead) nx = 4; else if (m_clr) nx = 3;
        3: if (m_key || kk == WF) nx = 0;
        4: if (m_key || kk == LF) nx = 0;
        default: nx = 0;
      endcase
    end
    chg   = (nx != m_state);
    kedge = k && !m_prev;
    m_prev = k;
    m_ng   = chg && (nx == 2);
    m_key  = (m_key  && !chg) || kedge;
    m_dead = (m_dead && !chg) || (d && m_state == 2);
    m_clr  = (m_clr  && !chg) || (c && m_state == 2);
    if (chg) begin m_state = nx; m_k = 0; end
    else if (s) m_k = kk;
    #1;
  endtask

  // One frame: sof on the first cycle, events mid-frame.
  task automatic frame(input bit kev, input bit dev, input bit cev);
    for (int c = 0; c < FL; c++) begin
      if (kev && c == 1) key_lvl = 0;
      if (kev && c == 3) key_lvl = 1;
      tick(c == 0, key_lvl, dev && c == 3, cev && c == 3, rx(), ry());
    end
  endtask

  task automatic goto_play();
    key_lvl = 0;
    frame(1, 0, 0);
    key_lvl = 0;
    for (int i = 0; i < RF + 1; i++) frame(0, 0, 0);
  endtask

  task automatic test_reset();
    resetN = 1'b0; key_lvl = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 13'h0) begin
      errors++; $display("FAIL reset_values: got %h want %h", dut_vec, 13'h0);
    end
    resetN = 1'b1;
  endtask

  task automatic test_start_idle();
    logic [7:0] want;
    for (int f = 1; f <= 65; f++) begin
      frame(0, 0, 0);
      tick(0, key_lvl, 0, 0, 300, 240);
      want = (((f / BF) % 2) == 1) ? 8'hFF : 8'h03;
      checks++;
      if (RGB_game_sm !== want) begin
        errors++; $display("FAIL start_blink f=%0d: got %h want %h", f, RGB_game_sm, want);
      end
      tick(0, key_lvl, 0, 0, 0, 0);
      checks++;
      if ({game_on, screen_state, RGB_game_sm} !== {1'b0, 3'd0, 8'h03}) begin
        errors++; $display("FAIL start_idle f=%0d: got %b/%0d/%h want 0/0/03",
                           f, game_on, screen_state, RGB_game_sm);
      end
    end
  endtask

  task automatic test_ready_play();
    frame(1, 0, 0);
    checks++;
    if (screen_state !== 3'd0) begin
      errors++; $display("FAIL key_midframe_no_change: got %0d want 0", screen_state);
    end
    frame(0, 0, 0);
    checks++;
    if (screen_state !== 3'd1) begin
      errors++; $display("FAIL enter_ready: got %0d want 1", screen_state);
    end
    for (int f = 1; f < RF; f++) begin
      frame(0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec() || screen_state !== 3'd1) begin
        errors++; $display("FAIL ready_hold f=%0d: got %h want %h", f, dut_vec, exp_vec());
      end
    end
    tick(1, key_lvl, 0, 0, rx(), ry());
    checks++;
    if ({game_on, new_game, screen_state} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL enter_play: got %b%b/%0d want 11/2", game_on, new_game, screen_state);
    end
    tick(0, key_lvl, 0, 0, rx(), ry());
    checks++;
    if (new_game !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL new_game_one_cycle: got %h want %h", dut_vec, exp_vec());
    end
    for (int c = 2; c < FL; c++) tick(0, key_lvl, 0, 0, rx(), ry());
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, 0);
      checks++;
      if (screen_state !== 3'd2 || RGB_game_sm !== 8'h00) begin
        errors++; $display("FAIL play_key_held: got %0d/%h want 2/00", screen_state, RGB_game_sm);
      end
    end
    key_lvl = 0;
  endtask

  task automatic test_lose_both();
    frame(0, 1, 1);
    checks++;
    if (screen_state !== 3'd2) begin
      errors++; $display("FAIL event_one_frame_latency: got %0d want 2", screen_state);
    end
    frame(0, 0, 0);
    tick(0, key_lvl, 0, 0, 0, 0);
    checks++;
    if ({screen_state, RGB_game_sm} !== {3'd4, 8'hE0}) begin
      errors++; $display("FAIL lose_priority: got %0d/%h want 4/e0", screen_state, RGB_game_sm);
    end
    for (int f = 1; f < LF; f++) begin
      frame(0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL lose_hold f=%0d: got %h want %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (screen_state !== 3'd4) begin
      errors++; $display("FAIL lose_last_frame: got %0d want 4", screen_state);
    end
    frame(0, 0, 0);
    checks++;
    if (screen_state !== 3'd0) begin
      errors++; $display("FAIL lose_timeout: got %0d want 0", screen_state);
    end
    for (int f = 0; f < 3; f++) begin
      frame(0, 1, 1);
      frame(0, 0, 0);
      checks++;
      if (screen_state !== 3'd0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL start_ignores_dead: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_win_skip();
    goto_play();
    checks++;
    if (screen_state !== 3'd2) begin
      errors++; $display("FAIL win_setup_play: got %0d want 2", screen_state);
    end
    frame(0, 0, 1);
    frame(0, 0, 0);
    tick(0, key_lvl, 0, 0, 0, 0);
    checks++;
    if ({screen_state, RGB_game_sm} !== {3'd3, 8'h1C}) begin
      errors++; $display("FAIL enter_win: got %0d/%h want 3/1c", screen_state, RGB_game_sm);
    end
    for (int f = 2; f < 10; f++) frame(0, 0, 0);
    frame(1, 0, 0);
    checks++;
    if (screen_state !== 3'd3) begin
      errors++; $display("FAIL win_key_midframe: got %0d want 3", screen_state);
    end
    frame(0, 0, 0);
    checks++;
    if (screen_state !== 3'd0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL win_key_skip: got %h want %h", dut_vec, exp_vec());
    end
    key_lvl = 0;
  endtask

  task automatic test_random();
    bit kev, dev, cev;
    for (int f = 0; f < 400; f++) begin
      kev = ($urandom_range(0, 9) == 0);
      dev = ($urandom_range(0, 19) == 0);
      cev = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) key_lvl = 0;
      frame(kev, dev, cev);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random f=%0d: got %h want %h", f, dut_vec, exp_vec());
      end
    end
    key_lvl = 0;
  endtask

  task automatic test_reset_win();
    goto_play();
    frame(0, 0, 1);
    for (int f = 0; f < 5; f++) frame(0, 0, 0);
    checks++;
    if (screen_state !== 3'd3) begin
      errors++; $display("FAIL reset_setup_win: got %0d want 3", screen_state);
    end
    #3 resetN = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 13'h0) begin
      errors++; $display("FAIL async_reset: got %h want %h", dut_vec, 13'h0);
    end
    model_reset();
    key_lvl = 0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    for (int f = 0; f < 3; f++) frame(0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if ({game_on, screen_state, RGB_game_sm} !== {1'b0, 3'd0, 8'h03}) begin
      errors++; $display("FAIL after_reset_start: got %b/%0d/%h want 0/0/03",
                         game_on, screen_state, RGB_game_sm);
    end
  endtask

  initial begin
    test_reset();
    test_start_idle();
    test_ready_play();
    test_lose_both();
    test_win_skip();
    test_random();
    test_reset_win();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
